apb_master_bridge: RTL

Single-clock APB initiator: it converts a simple valid/ready request port into APB SETUP/ACCESS transfers, and returns read data and error status on a one-cycle response strobe. It sits between an on-chip controller (debug bridge or DMA front end) and the APB peripheral slaves, such as the PWM register block. It supports PREADY wait states, PSLVERR and a bounded-wait timeout, and it rejects misaligned addresses without driving the bus.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the APB initiator bridge and by the APB
// slave blocks that hang off it.
//   apb_state_t        : SETUP/ACCESS transfer phases plus IDLE
//   APB_BYTES_PER_WORD : bytes per data word; sets the address alignment rule
//   APB_ADDR_WIDTH     : default PADDR width
//   APB_DATA_WIDTH     : default PWDATA/PRDATA width
// ---------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_BYTES_PER_WORD = 4;
  localparam int APB_ALIGN_BITS     = $clog2(APB_BYTES_PER_WORD);
  localparam int APB_ADDR_WIDTH     = 32;
  localparam int APB_DATA_WIDTH     = 32;

endpackage : apb_pkg

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Converts a valid/ready request port into APB SETUP/ACCESS transfers and
// returns read data and error status on a one-cycle response strobe.
// Misaligned requests are rejected without touching the bus; an ACCESS phase
// that sees PREADY low for TIMEOUT cycles is aborted.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_write/addr/wdata     : request payload (byte address)
//   rsp_valid                : one-cycle response strobe, no backpressure
//   rsp_rdata/err/timeout    : response payload, held until next response
//   PADDR/PWDATA/PWRITE      : APB payload, held between transfers
//   PSEL/PENABLE             : APB phase control
//   PRDATA/PREADY/PSLVERR    : APB slave response
// DATA_WIDTH must be 32; TIMEOUT must lie in 1..255.
// ---------------------------------------------------------------------------
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  // Abort happens on the edge where the incremented count would reach TIMEOUT.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  misaligned;

  assign misaligned = (req_addr[APB_ALIGN_BITS-1:0] != '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            // Rejected locally: bus payload registers are left untouched.
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d  = SETUP;
            cnt_d    = '0;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            pwrite_d = req_write;
          end
        end
      end

      SETUP: state_d = ACCESS;

      ACCESS: begin
        if (PREADY) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d       = IDLE;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Phase controls decode straight from the state register, so PENABLE can
  // never be high without PSEL and both drop with the asynchronous reset.
  assign req_ready   = (state_q == IDLE);
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule : apb_master_bridge
